i2c_poll_scheduler: RTL and testbench



---
 rtl/temp_sensor_pkg.sv | 28 ++
 rtl/i2c_poll_scheduler_poll_timer.sv | 33 +++
 rtl/i2c_poll_scheduler.sv | 142 ++++++++++++++
 tb/tb_i2c_poll_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_sensor_pkg.sv
// Shared opcodes, grant tags and FSM states for the
// I2C poll scheduler.
package temp_sensor_pkg;

  localparam logic [7:0] MODE_RD1 = 8'h01;
  localparam logic [7:0] MODE_RD2 = 8'h02;
  localparam logic [7:0] MODE_WR1 = 8'h03;
  localparam logic [7:0] MODE_WR2 = 8'h04;

  localparam logic [1:0] VALID_NONE    = 2'b00;
  localparam logic [1:0] VALID_DEFAULT = 2'b01;
  localparam logic [1:0] VALID_PC      = 2'b10;

  localparam logic [7:0] TEMP_REG_ADDR = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } sched_state_t;

  function automatic logic mode_ok(input logic [7:0] m);
    return (m == MODE_RD1) || (m == MODE_RD2) ||
           (m == MODE_WR1) || (m == MODE_WR2);
  endfunction

endpackage

// File: rtl/i2c_poll_scheduler_poll_timer.sv
// Free-running poll period counter; raises a single
// pending flag per period, cleared by a poll grant.
module poll_timer #(
  parameter int unsigned POLL_CYCLES = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic grant_poll,
  output logic poll_pending
);

  localparam int W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  logic [W-1:0] cnt;
  logic         tc;

  assign tc = (cnt == W'(POLL_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      poll_pending <= 1'b0;
    end else begin
      cnt <= tc ? '0 : cnt + W'(1);
      // A fresh period wins over a same-cycle grant.
      if (tc)
        poll_pending <= 1'b1;
      else if (grant_poll)
        poll_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/i2c_poll_scheduler.sv
// Arbitrates PC FIFO instructions against the periodic
// temperature poll and sequences the i2cmaster handshake.
module i2c_poll_scheduler
  import temp_sensor_pkg::*;
#(
  parameter int unsigned POLL_CYCLES  = 25000000,
  parameter int unsigned MAX_PC_BURST = 4,
  parameter int unsigned ACK_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_valid,
  input  logic [7:0]  pc_mode,
  input  logic [7:0]  pc_addr,
  input  logic [15:0] pc_data,
  output logic        pc_pop,
  input  logic        master_free,
  input  logic        full_i2cbuffer,
  output logic        initiate,
  output logic [7:0]  i2c_mode,
  output logic [7:0]  i2c_address,
  output logic [15:0] i2c_data,
  output logic [1:0]  valid_instr,
  output logic        poll_pending,
  output logic        issue_fault,
  output logic        bad_op
);

  localparam int BW = $clog2(MAX_PC_BURST + 1);
  localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  sched_state_t  state;
  sched_state_t  state_next;
  logic [BW-1:0] burst;
  logic [AW-1:0] ack_cnt;
  logic          bad_op_q;

  logic can_grant;
  logic burst_ok;
  logic grant_pc;
  logic grant_poll;
  logic start_pc;
  logic drop_pc;
  logic ack_expired;

  poll_timer #(
    .POLL_CYCLES (POLL_CYCLES)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .grant_poll   (grant_poll),
    .poll_pending (poll_pending)
  );

  // No decision while a discarded entry is being popped.
  assign can_grant = (state == IDLE) && master_free &&
                     !full_i2cbuffer && !bad_op_q;
  assign burst_ok  = (burst < BW'(MAX_PC_BURST)) || !poll_pending;
  assign grant_pc  = can_grant && pc_valid && burst_ok;
  assign grant_poll = can_grant && !grant_pc && poll_pending;
  assign start_pc  = grant_pc && mode_ok(pc_mode);
  assign drop_pc   = grant_pc && !mode_ok(pc_mode);

  assign ack_expired = (state == WAIT_ACK) && master_free &&
                       (ack_cnt == AW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:
        if (start_pc || grant_poll)
          state_next = ISSUE;
      ISSUE:
        state_next = WAIT_ACK;
      WAIT_ACK:
        if (!master_free)
          state_next = WAIT_DONE;
        else if (ack_expired)
          state_next = IDLE;
      WAIT_DONE:
        if (master_free)
          state_next = IDLE;
      default:
        state_next = IDLE;
    endcase
  end

  always_comb begin
    initiate    = (state == ISSUE);
    pc_pop      = ((state == ISSUE) && (valid_instr == VALID_PC)) ||
                  bad_op_q;
    bad_op      = bad_op_q;
    issue_fault = ack_expired;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i2c_mode    <= '0;
      i2c_address <= '0;
      i2c_data    <= '0;
      valid_instr <= VALID_NONE;
      burst       <= '0;
      ack_cnt     <= '0;
      bad_op_q    <= 1'b0;
    end else begin
      bad_op_q <= drop_pc;

      if (start_pc) begin
        i2c_mode    <= pc_mode;
        i2c_address <= pc_addr;
        i2c_data    <= pc_data;
        valid_instr <= VALID_PC;
      end else if (grant_poll) begin
        i2c_mode    <= MODE_RD2;
        i2c_address <= TEMP_REG_ADDR;
        i2c_data    <= '0;
        valid_instr <= VALID_DEFAULT;
      end

      if (grant_poll)
        burst <= '0;
      else if (start_pc) begin
        if (burst != BW'(MAX_PC_BURST))
          burst <= burst + BW'(1);
      end else if ((state == IDLE) && !poll_pending)
        burst <= '0;

      if (state == WAIT_ACK)
        ack_cnt <= ack_cnt + AW'(1);
      else
        ack_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_i2c_poll_scheduler.sv
// Scoreboard bench: FIFO and master models drive the DUT,
// a monitor checks every initiate / bad_op / fault event.
module tb_i2c_poll_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_valid = 1'b0;
  logic [7:0]  pc_mode = '0;
  logic [7:0]  pc_addr = '0;
  logic [15:0] pc_data = '0;
  logic        master_free = 1'b1;
  logic        full = 1'b0;
  logic        pc_pop;
  logic        initiate;
  logic [7:0]  i2c_mode;
  logic [7:0]  i2c_address;
  logic [15:0] i2c_data;
  logic [1:0]  valid_instr;
  logic        poll_pending;
  logic        issue_fault;
  logic        bad_op;

  always #5 clk = ~clk;

  i2c_poll_scheduler #(
    .POLL_CYCLES  (100),
    .MAX_PC_BURST (2),
    .ACK_TIMEOUT  (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_valid       (pc_valid),
    .pc_mode        (pc_mode),
    .pc_addr        (pc_addr),
    .pc_data        (pc_data),
    .pc_pop         (pc_pop),
    .master_free    (master_free),
    .full_i2cbuffer (full),
    .initiate       (initiate),
    .i2c_mode       (i2c_mode),
    .i2c_address    (i2c_address),
    .i2c_data       (i2c_data),
    .valid_instr    (valid_instr),
    .poll_pending   (poll_pending),
    .issue_fault    (issue_fault),
    .bad_op         (bad_op)
  );

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  a;
    logic [15:0] d;
  } pc_t;

  typedef struct {
    int          kind;
    int          at;
    logic [7:0]  m;
    logic [7:0]  a;
    logic [15:0] d;
    logic [1:0]  vi;
  } exp_t;

  pc_t  fifo[$];
  exp_t sb[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  bit   dead = 1'b0;

  always @(posedge clk)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act === req)
      passed++;
    else
      $display("FAIL %s: got %0h want %0h at cycle %0d",
               name, act, req, cyc);
  endtask

  task automatic exp_issue(input int at, input logic [7:0] m,
                           input logic [7:0] a,
                           input logic [15:0] d,
                           input logic [1:0] vi);
    exp_t e;
    e.kind = 1; e.at = at; e.m = m; e.a = a; e.d = d; e.vi = vi;
    sb.push_back(e);
  endtask

  task automatic exp_event(input int kind, input int at);
    exp_t e;
    e.kind = kind; e.at = at; e.m = '0; e.a = '0; e.d = '0;
    e.vi = '0;
    sb.push_back(e);
  endtask

  task automatic push_pc(input logic [7:0] m, input logic [7:0] a,
                         input logic [15:0] d);
    pc_t p;
    p.m = m; p.a = a; p.d = d;
    fifo.push_back(p);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_zero();
    chk("reset_fields", {i2c_mode, i2c_address, i2c_data}, 32'h0);
    chk("reset_flags", {initiate, pc_pop, valid_instr,
                        poll_pending, issue_fault, bad_op}, 32'h0);
  endtask

  // FIFO model: head updates the cycle after a pop
  initial begin
    logic p;
    forever begin
      @(negedge clk);
      p = pc_pop;
      @(posedge clk);
      #1;
      if (reset)
        fifo.delete();
      else if (p && fifo.size() > 0)
        void'(fifo.pop_front());
      pc_valid = (fifo.size() > 0);
      if (fifo.size() > 0) begin
        pc_mode = fifo[0].m;
        pc_addr = fifo[0].a;
        pc_data = fifo[0].d;
      end
    end
  end

  // Master model: busy from initiate+2 to initiate+12
  initial begin
    forever begin
      @(negedge clk);
      if (initiate && !dead && !reset) begin
        repeat (2) @(posedge clk);
        #1 master_free = 1'b0;
        repeat (10) @(posedge clk);
        #1 master_free = 1'b1;
      end
    end
  end

  initial begin
    logic [2:0] k;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        k = {issue_fault, bad_op, initiate};
        if (k == 3'b000) begin
          if (pc_pop) chk("stray_pop", {31'h0, pc_pop}, 32'h0);
        end else if (sb.size() == 0) begin
          chk("unexpected_event", {29'h0, k}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("event_kind", {29'h0, k}, e.kind);
          if (e.at >= 0) chk("event_cycle", cyc, e.at);
          if (e.kind == 1) begin
            chk("i2c_mode", {24'h0, i2c_mode}, {24'h0, e.m});
            chk("i2c_address", {24'h0, i2c_address}, {24'h0, e.a});
            chk("i2c_data", {16'h0, i2c_data}, {16'h0, e.d});
            chk("valid_instr", {30'h0, valid_instr}, {30'h0, e.vi});
            chk("issue_pop", {31'h0, pc_pop},
                {31'h0, (e.vi == 2'b10)});
            if (e.vi == 2'b01)
              chk("pending_cleared", {31'h0, poll_pending}, 32'h0);
          end else if (e.kind == 2) begin
            chk("bad_op_pop", {31'h0, pc_pop}, 32'h1);
          end else begin
            chk("fault_no_pop", {31'h0, pc_pop}, 32'h0);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    // idle polling
    do_reset();
    @(negedge clk);
    check_zero();
    exp_issue(101, 8'h02, 8'h00, 16'h0000, 2'b01);
    exp_issue(201, 8'h02, 8'h00, 16'h0000, 2'b01);
    exp_issue(301, 8'h02, 8'h00, 16'h0000, 2'b01);
    wait_cyc(330);

    // single PC write, then the next periodic poll
    push_pc(8'h03, 8'h01, 16'h00A5);
    exp_issue(332, 8'h03, 8'h01, 16'h00A5, 2'b10);
    exp_issue(401, 8'h02, 8'h00, 16'h0000, 2'b01);
    wait_cyc(420);

    // burst limit with a pending poll
    do_reset();
    wait_cyc(5);
    full = 1'b1;
    wait_cyc(10);
    push_pc(8'h01, 8'h10, 16'h0000);
    push_pc(8'h02, 8'h11, 16'h0000);
    push_pc(8'h03, 8'h12, 16'h1234);
    push_pc(8'h04, 8'h13, 16'hBEEF);
    push_pc(8'h01, 8'h14, 16'h0000);
    exp_issue(101, 8'h01, 8'h10, 16'h0000, 2'b10);
    exp_issue(115, 8'h02, 8'h11, 16'h0000, 2'b10);
    exp_issue(129, 8'h02, 8'h00, 16'h0000, 2'b01);
    exp_issue(143, 8'h03, 8'h12, 16'h1234, 2'b10);
    exp_issue(157, 8'h04, 8'h13, 16'hBEEF, 2'b10);
    exp_issue(171, 8'h01, 8'h14, 16'h0000, 2'b10);
    wait_cyc(100);
    full = 1'b0;
    @(negedge clk);
    chk("pending_raised", {31'h0, poll_pending}, 32'h1);
    wait_cyc(190);

    // malformed opcode dropped, next entry granted
    do_reset();
    wait_cyc(10);
    push_pc(8'h07, 8'h20, 16'h0000);
    push_pc(8'h04, 8'h21, 16'hCAFE);
    exp_event(2, 12);
    exp_issue(14, 8'h04, 8'h21, 16'hCAFE, 2'b10);
    wait_cyc(40);

    // master never starts
    do_reset();
    dead = 1'b1;
    wait_cyc(10);
    push_pc(8'h02, 8'h30, 16'h0000);
    push_pc(8'h01, 8'h31, 16'h0000);
    exp_issue(12, 8'h02, 8'h30, 16'h0000, 2'b10);
    exp_event(4, 20);
    exp_issue(22, 8'h01, 8'h31, 16'h0000, 2'b10);
    wait_cyc(21);
    dead = 1'b0;
    wait_cyc(50);

    // downstream full while a poll becomes pending
    do_reset();
    wait_cyc(90);
    push_pc(8'h03, 8'h40, 16'h0042);
    exp_issue(92, 8'h03, 8'h40, 16'h0042, 2'b10);
    exp_issue(121, 8'h02, 8'h00, 16'h0000, 2'b01);
    wait_cyc(98);
    full = 1'b1;
    wait_cyc(110);
    @(negedge clk);
    chk("pending_while_full", {31'h0, poll_pending}, 32'h1);
    wait_cyc(120);
    full = 1'b0;
    wait_cyc(140);

    // reset in WAIT_ACK
    do_reset();
    wait_cyc(10);
    push_pc(8'h01, 8'h50, 16'h0000);
    exp_issue(12, 8'h01, 8'h50, 16'h0000, 2'b10);
    wait_cyc(13);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero();
    @(posedge clk);
    #1 reset = 1'b0;
    exp_issue(101, 8'h02, 8'h00, 16'h0000, 2'b01);
    wait_cyc(115);

    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
